capture_arbiter: RTL and testbench

Synthesizable scheduler that shares one parameterized capture register among `NREQ` requesters. It replaces simulation-only `#delay` timing with a cycle-counted delay. It arbitrates round-robin between requesters and waits `DELAY` clock cycles after each grant. It then captures the granted requester's `SIZE`-bit word into `out` and pulses `done`. It sits between the requesting datapath blocks and the shared registered output stage.

---
 rtl/capture_arbiter_pkg.sv | 14 +
 rtl/capture_arbiter_rr_arbiter.sv | 29 ++
 rtl/capture_arbiter.sv | 79 +++++++
 tb/tb_capture_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/capture_arbiter_pkg.sv
// Shared constants, state encoding and parameter check for the capture arbiter.
package capture_arbiter_pkg;

  localparam int CNT_W = 8;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_WAIT = 1'b1;

  function automatic bit params_ok(input int size, input int delay, input int nreq);
    return (size >= 1) && (delay >= 1) && (delay <= 255) && (nreq >= 2) && (nreq <= 8);
  endfunction

endpackage

// File: rtl/capture_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr+1.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         pick,
  output logic [$clog2(NREQ)-1:0] pick_idx
);

  localparam int PTR_W = $clog2(NREQ);

  always_comb begin
    automatic int  idx;
    automatic bit  found;
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/capture_arbiter.sv
// Round-robin scheduler sharing one capture register; captures the winner's word
// DELAY cycles after the grant and pulses done.
//
// state   | meaning
// IDLE    | no grant outstanding, arbitrating on req
// WAIT    | grant held, counting down to the capture edge
module capture_arbiter
  import capture_arbiter_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int DELAY = 2,
  parameter int NREQ  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] in_bus,
  output logic [NREQ-1:0]      gnt,
  output logic [SIZE-1:0]      out,
  output logic                 done,
  output logic                 busy
);

  localparam int PTR_W = $clog2(NREQ);

  if (!params_ok(SIZE, DELAY, NREQ)) begin : g_bad_params
    $error("capture_arbiter: illegal SIZE/DELAY/NREQ combination");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   ptr;
  logic [NREQ-1:0]    pick;
  logic [PTR_W-1:0]   pick_idx;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req      (req),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  assign busy = (state == ST_WAIT);

  // ptr doubles as the current winner while in WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt   <= '0;
      out   <= '0;
      done  <= 1'b0;
      cnt   <= '0;
      ptr   <= PTR_W'(NREQ - 1);
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (|req) begin
          gnt   <= pick;
          ptr   <= pick_idx;
          cnt   <= CNT_W'(DELAY);
          state <= ST_WAIT;
        end
      end else begin
        if (!req[ptr]) begin
          gnt   <= '0;
          state <= ST_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          out   <= in_bus[int'(ptr)*SIZE +: SIZE];
          done  <= 1'b1;
          gnt   <= '0;
          state <= ST_IDLE;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_capture_arbiter.sv
// Self-checking bench for capture_arbiter using a transaction-level round-robin model.
module tb_capture_arbiter;

  localparam int SZ = 7;
  localparam int D  = 4;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*SZ-1:0] in_bus;
  logic [N-1:0]    gnt;
  logic [SZ-1:0]   out;
  logic            done;
  logic            busy;

  int passed = 0;
  int total  = 0;
  int exp_last;
  logic [SZ-1:0] exp_out;

  capture_arbiter #(.SIZE(SZ), .DELAY(D), .NREQ(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .in_bus (in_bus),
    .gnt    (gnt),
    .out    (out),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [SZ-1:0] slice(input logic [N*SZ-1:0] b, input int i);
    return b[i*SZ +: SZ];
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"},  32'(gnt),  32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_out"},  32'(out),  32'(exp_out));
  endtask

  // One transfer from IDLE: grant, countdown, then capture or abort at edge abort_at.
  task automatic xfer(input string tag, input logic [N-1:0] r, input logic [N*SZ-1:0] data,
                      input bit abort, input int abort_at);
    int w;
    w      = rr_pick(r, exp_last);
    req    = r;
    in_bus = data;
    step();
    chk({tag, "_grant"}, 32'(gnt), 32'(1) << w);
    chk({tag, "_busy"},  32'(busy), 32'h1);
    chk({tag, "_done0"}, 32'(done), 32'h0);
    exp_last = w;
    for (int k = 1; k <= D; k++) begin
      if (abort && k == abort_at) begin
        req[w] = 1'b0;
        step();
        check_idle_outputs({tag, "_abort"});
        return;
      end
      step();
      if (k < D) begin
        chk({tag, "_hold_gnt"}, 32'(gnt), 32'(1) << w);
        chk({tag, "_hold_out"}, 32'(out), 32'(exp_out));
        chk({tag, "_hold_done"}, 32'(done), 32'h0);
      end else begin
        exp_out = slice(data, w);
        chk({tag, "_cap_out"},  32'(out),  32'(exp_out));
        chk({tag, "_cap_done"}, 32'(done), 32'h1);
        chk({tag, "_cap_gnt"},  32'(gnt),  32'h0);
        chk({tag, "_cap_busy"}, 32'(busy), 32'h0);
      end
    end
  endtask

  task automatic go_idle();
    req = '0;
    step();
    chk("idle_done", 32'(done), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    logic [N*SZ-1:0] d;
    int ab;
    rst    = 1'b1;
    req    = 4'b1111;
    in_bus = '0;
    step();
    step();
    exp_last = N - 1;
    exp_out  = '0;
    check_idle_outputs("reset");
    rst = 1'b0;

    // first grant after reset goes to requester 0
    xfer("first", 4'b1111, {$urandom, $urandom}, 1'b0, 0);
    go_idle();

    d = '0;
    d[2*SZ +: SZ] = 7'h55;
    xfer("single", 4'b0100, d, 1'b0, 0);
    step();
    chk("single_done_pulse", 32'(done), 32'h0);
    req = '0;
    step();

    // fairness: back-to-back with req held, order follows the model from ptr=2
    for (int i = 0; i < 6; i++) xfer("rr", 4'b1011, {$urandom, $urandom}, 1'b0, 0);
    go_idle();

    // abort on requester 1, next grant moves on to 2
    xfer("pre_abort", 4'b0001, {$urandom, $urandom}, 1'b0, 0);
    go_idle();
    xfer("abort", 4'b0010, {$urandom, $urandom}, 1'b1, 2);
    xfer("post_abort", 4'b0110, {$urandom, $urandom}, 1'b0, 0);
    go_idle();

    // reset in the middle of a transfer
    req    = 4'b0100;
    in_bus = {$urandom, $urandom};
    step();
    chk("mid_gnt", 32'(gnt), 32'h4);
    step();
    rst = 1'b1;
    step();
    rst      = 1'b0;
    exp_last = N - 1;
    exp_out  = '0;
    check_idle_outputs("mid_reset");
    xfer("after_reset", 4'b1111, {$urandom, $urandom}, 1'b0, 0);
    go_idle();

    // pointer wrap
    xfer("wrap_a", 4'b1000, {$urandom, $urandom}, 1'b0, 0);
    go_idle();
    xfer("wrap_b", 4'b1000, {$urandom, $urandom}, 1'b0, 0);
    go_idle();
    xfer("wrap_c", 4'b1001, {$urandom, $urandom}, 1'b0, 0);
    go_idle();

    for (int i = 0; i < 25; i++) begin
      logic [N-1:0] r;
      r  = N'($urandom_range(1, (1 << N) - 1));
      ab = ($urandom_range(0, 3) == 0) ? 1 : 0;
      xfer("rand", r, {$urandom, $urandom}, ab[0], $urandom_range(1, D));
      if ($urandom_range(0, 1) == 1) go_idle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
